// File: rtl/sort_result_streamer.sv
// Streams the settled output of the odd-even transposition sorter, smallest first, over valid/ready.
// Optional capture-order check enabled by defining SORT_RESULT_CHECK_EN.
module sort_result_streamer #(
  parameter int N_ELEM        = 5,
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           sorted_in [N_ELEM],
  output logic                       busy,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(N_ELEM)-1:0]  out_index,
  output logic [7:0]                 frame_count,
  output logic                       sort_err
);

  localparam int IDX_W = $clog2(N_ELEM);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] buf_r [N_ELEM];
  logic [WIDTH-1:0] out_data_r;
  logic             busy_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic [7:0]       frame_count_r;
  logic [IDX_W-1:0] next_idx_s;
  logic             capture_s;

  assign next_idx_s = idx_r + IDX_W'(1);
  assign capture_s  = (state_r == ST_SETTLE) && (cnt_r == CNT_W'(0));

  // Frame sequencing: settle countdown, capture, and beat-by-beat output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_W'(0);
      idx_r         <= IDX_W'(0);
      out_data_r    <= WIDTH'(0);
      busy_r        <= 1'b0;
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
      frame_count_r <= 8'd0;
      for (int i = 0; i < N_ELEM; i++) buf_r[i] <= WIDTH'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_SETTLE;
            cnt_r   <= CNT_LOAD;
            busy_r  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_r != CNT_W'(0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else begin
            for (int i = 0; i < N_ELEM; i++) buf_r[i] <= sorted_in[i];
            state_r     <= ST_STREAM;
            idx_r       <= IDX_W'(0);
            out_data_r  <= sorted_in[0];
            out_valid_r <= 1'b1;
            out_last_r  <= (LAST_IDX == IDX_W'(0));
          end
        end
        ST_STREAM: begin
          // The next element is preloaded so out_data never depends on out_ready combinationally.
          if (out_ready) begin
            if (idx_r == LAST_IDX) begin
              state_r       <= ST_IDLE;
              busy_r        <= 1'b0;
              out_valid_r   <= 1'b0;
              out_last_r    <= 1'b0;
              frame_count_r <= frame_count_r + 8'd1;
            end else begin
              idx_r      <= next_idx_s;
              out_data_r <= buf_r[next_idx_s];
              out_last_r <= (next_idx_s == LAST_IDX);
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign out_last    = out_last_r;
  assign out_index   = idx_r;
  assign frame_count = frame_count_r;

`ifdef SORT_RESULT_CHECK_EN
  logic sort_err_r;

  function automatic logic order_violation(input logic [WIDTH-1:0] v [N_ELEM]);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_ELEM - 1; i++) begin
      if (v[i] > v[i+1]) bad = 1'b1;
    end
    return bad;
  endfunction

  // Order flag: evaluated on the values being captured, held until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sort_err_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      sort_err_r <= 1'b0;
    end else if (capture_s) begin
      sort_err_r <= order_violation(sorted_in);
    end
  end

  assign sort_err = sort_err_r;
`else
  logic unused_capture_s;
  assign unused_capture_s = capture_s;
  assign sort_err = 1'b0;
`endif

endmodule
